// File: rtl/uart_imem_loader.sv
// uart_imem_loader: byte-command loader between the UART FIFOs and the CPU.
// It decodes the L/R/H commands, assembles little-endian words into
// instruction memory, answers each command with one ACK/NAK byte and
// drives the CPU run flag.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the load data.
module uart_imem_loader #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int NB_UART_DATA    = 8
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_UART_DATA-1:0]    i_rx_data,
  input  logic                       i_rx_empty,
  output logic                       o_rd,
  input  logic                       i_tx_full,
  output logic                       o_wr,
  output logic [NB_UART_DATA-1:0]    o_wdata,
  output logic                       o_tx_start,
  output logic                       o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_wdata,
  output logic                       o_cpu_run,
  output logic                       o_busy
);
  localparam int BPW    = NB_INSTRUCTION / NB_UART_DATA;
  localparam int BIW    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NB_CNT = 2 * NB_UART_DATA;

  localparam logic [NB_UART_DATA-1:0] CMD_LOAD = NB_UART_DATA'(8'h4C);
  localparam logic [NB_UART_DATA-1:0] CMD_RUN  = NB_UART_DATA'(8'h52);
  localparam logic [NB_UART_DATA-1:0] CMD_HALT = NB_UART_DATA'(8'h48);
  localparam logic [NB_UART_DATA-1:0] ACK      = NB_UART_DATA'(8'h06);
  localparam logic [NB_UART_DATA-1:0] NAK      = NB_UART_DATA'(8'h15);

  typedef enum logic [3:0] {
    IDLE, CMD_DEC, CNT_LO, CNT_HI, DATA, WRITE, CSUM, RESP, TXSTART
  } state_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_RUN, ACT_HALT} act_t;

  state_t                      state, state_nx;
  act_t                        act, act_nx;
  logic [NB_UART_DATA-1:0]     cmd;
  logic [NB_UART_DATA-1:0]     resp, resp_nx;
  logic [NB_CNT-1:0]           cnt;
  logic [NB_INSTRUCTION-1:0]   asm_word;
  logic [BIW-1:0]              byte_idx;
  logic [IMEM_ADDR_WIDTH:0]    word_idx;
  logic                        run;
  logic                        rd, wr;
  logic [NB_CNT-1:0]           n_c;
  logic                        too_big, last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [NB_UART_DATA-1:0]     csum;
`endif

  // Count as it stands once the high byte at the RX head is taken.
  assign n_c       = {i_rx_data, cnt[NB_UART_DATA-1:0]};
  assign too_big   = 32'(n_c) > (32'd1 << IMEM_ADDR_WIDTH);
  assign last_word = (32'(word_idx) + 32'd1) >= 32'(cnt);

  // State register.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      resp  <= '0;
      act   <= ACT_NONE;
    end else begin
      state <= state_nx;
      resp  <= resp_nx;
      act   <= act_nx;
    end
  end

  // Next-state decode, RX pop and TX push strobes.
  always_comb begin
    state_nx = state;
    resp_nx  = resp;
    act_nx   = act;
    rd       = 1'b0;
    wr       = 1'b0;
    case (state)
      IDLE: if (!i_rx_empty) begin
        rd       = 1'b1;
        state_nx = CMD_DEC;
      end
      CMD_DEC: begin
        act_nx = ACT_NONE;
        if (cmd == CMD_LOAD && !run) begin
          state_nx = CNT_LO;
        end else begin
          state_nx = RESP;
          resp_nx  = NAK;
          if (cmd == CMD_RUN) begin
            resp_nx = ACK;
            act_nx  = ACT_RUN;
          end else if (cmd == CMD_HALT) begin
            resp_nx = ACK;
            act_nx  = ACT_HALT;
          end
        end
      end
      CNT_LO: if (!i_rx_empty) begin
        rd       = 1'b1;
        state_nx = CNT_HI;
      end
      CNT_HI: if (!i_rx_empty) begin
        rd = 1'b1;
        if (n_c == '0) begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = RESP;
          resp_nx  = ACK;
`endif
        end else if (too_big) begin
          state_nx = RESP;
          resp_nx  = NAK;
        end else begin
          state_nx = DATA;
        end
      end
      DATA: if (!i_rx_empty) begin
        rd = 1'b1;
        if (byte_idx == BIW'(BPW - 1)) state_nx = WRITE;
      end
      WRITE: begin
        if (!last_word) begin
          state_nx = DATA;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = RESP;
          resp_nx  = ACK;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (!i_rx_empty) begin
        rd       = 1'b1;
        state_nx = RESP;
        resp_nx  = (i_rx_data == csum) ? ACK : NAK;
      end
`endif
      RESP: if (!i_tx_full) begin
        wr       = 1'b1;
        state_nx = TXSTART;
      end
      TXSTART: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: command latch, count, word assembly, indices and run flag.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd      <= '0;
      cnt      <= '0;
      asm_word <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      run      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      if (rd) begin
        case (state)
          IDLE:   cmd <= i_rx_data;
          CNT_LO: cnt[NB_UART_DATA-1:0] <= i_rx_data;
          CNT_HI: begin
            cnt      <= n_c;
            byte_idx <= '0;
            word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
          DATA: begin
            asm_word[int'(byte_idx)*NB_UART_DATA +: NB_UART_DATA] <= i_rx_data;
            byte_idx <= (byte_idx == BIW'(BPW - 1)) ? '0 : byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ i_rx_data;
`endif
          end
          default: ;
        endcase
      end
      // Address is consumed during WRITE, so advance it at the end of that cycle.
      if (state == WRITE) word_idx <= word_idx + 1'b1;
      // Run flag changes on the same edge that the ACK leaves.
      if (wr && act == ACT_RUN)  run <= 1'b1;
      if (wr && act == ACT_HALT) run <= 1'b0;
    end
  end

  // RX pop is forced low while reset is held so every output reads zero.
  assign o_rd         = rd & i_rst;
  assign o_wr         = wr;
  assign o_wdata      = resp;
  assign o_tx_start   = (state == TXSTART);
  assign o_imem_we    = (state == WRITE);
  assign o_imem_addr  = word_idx[IMEM_ADDR_WIDTH-1:0];
  assign o_imem_wdata = asm_word;
  assign o_cpu_run    = run;
  assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized scoreboard bench for uart_imem_loader; honours LOADER_CHECKSUM_EN.
module tb_uart_imem_loader;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq32_t[$];
  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] b; logic run; } rs_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_empty = 1'b1;
  logic        o_rd;
  logic        i_tx_full = 1'b0;
  logic        o_wr;
  logic [7:0]  o_wdata;
  logic        o_tx_start;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_run;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  wr_t        wq[$];
  rs_t        rq[$];
  bit         gap_en = 1'b0;
  int         gap = 0;
  int         pop_cnt = 0;
  bit         take;
  bit         pend = 1'b0;
  logic       pend_run = 1'b0;
  bit         m_run = 1'b0;
  wr_t        ew;
  rs_t        er;

  uart_imem_loader #(.NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(10), .NB_UART_DATA(8)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty),
    .o_rd(o_rd), .i_tx_full(i_tx_full), .o_wr(o_wr), .o_wdata(o_wdata),
    .o_tx_start(o_tx_start), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_cpu_run(o_cpu_run), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // RX FIFO model: pops on o_rd, optional random empty gaps between bytes.
  always begin
    @(negedge clk);
    take = o_rd && !i_rx_empty;
    if (o_rd) begin
      checks++;
      if (i_rx_empty) begin
        errors++;
        $display("FAIL rd_while_empty: o_rd=1 with i_rx_empty=1 at %0t", $time);
      end
    end
    @(posedge clk); #1;
    if (take && rxq.size() != 0) begin
      void'(rxq.pop_front());
      pop_cnt++;
      gap = gap_en ? int'($urandom_range(0, 10)) : 0;
    end else if (gap > 0) begin
      gap--;
    end
    i_rx_empty = (rxq.size() == 0) || (gap > 0);
    i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Monitor: compares every write, response and tx_start against the scoreboard.
  always @(negedge clk) begin
    if (i_rst) begin
      if (pend || o_tx_start) begin
        checks++;
        if (o_tx_start !== pend || o_cpu_run !== pend_run) begin
          errors++;
          $display("FAIL tx_start/run: tx_start=%0b run=%0b required tx_start=%0b run=%0b",
                   o_tx_start, o_cpu_run, pend, pend_run);
        end
        pend = 1'b0;
      end
      if (o_imem_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL imem_write: unexpected addr=%0d data=%h", o_imem_addr, o_imem_wdata);
        end else begin
          ew = wq.pop_front();
          if (o_imem_addr !== ew.a || o_imem_wdata !== ew.d) begin
            errors++;
            $display("FAIL imem_write: addr=%0d data=%h required addr=%0d data=%h",
                     o_imem_addr, o_imem_wdata, ew.a, ew.d);
          end
        end
      end
      if (o_wr) begin
        checks++;
        if (rq.size() == 0 || i_tx_full) begin
          errors++;
          $display("FAIL tx_byte: unexpected o_wr data=%h tx_full=%0b", o_wdata, i_tx_full);
        end else begin
          er = rq.pop_front();
          if (o_wdata !== er.b) begin
            errors++;
            $display("FAIL tx_byte: got %h required %h", o_wdata, er.b);
          end
          pend     = 1'b1;
          pend_run = er.run;
        end
      end
    end
  end

  function automatic bq_t mk_load(input wq32_t w, input bit bad);
    bq_t b;
    logic [7:0] x = 8'h00;
    int n = w.size();
    b.push_back(8'h4C);
    b.push_back(8'(n));
    b.push_back(8'(n >> 8));
    foreach (w[k]) begin
      for (int j = 0; j < 4; j++) begin
        b.push_back(w[k][8*j +: 8]);
        x ^= w[k][8*j +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    b.push_back(bad ? ~x : x);
`else
    if (bad) x = 8'h00;
`endif
    return b;
  endfunction

  function automatic wq32_t rand_words(input int n);
    wq32_t w;
    for (int k = 0; k < n; k++) w.push_back($urandom);
    return w;
  endfunction

  // Reference model: interprets the host byte stream command by command.
  task automatic model_stream(input bq_t b);
    int i = 0;
    int n;
    logic [7:0]  c;
    logic [7:0]  x;
    logic [31:0] w;
    while (i < b.size()) begin
      c = b[i]; i++;
      if (c == 8'h4C && !m_run) begin
        n = int'(b[i]) + 256 * int'(b[i+1]);
        i += 2;
        if (n > 1024) begin
          rq.push_back('{b: 8'h15, run: m_run});
        end else begin
          x = 8'h00;
          for (int k = 0; k < n; k++) begin
            w = {b[i+3], b[i+2], b[i+1], b[i]};
            x = x ^ b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
            wq.push_back('{a: 10'(k), d: w});
            i += 4;
          end
`ifdef LOADER_CHECKSUM_EN
          rq.push_back('{b: (b[i] == x) ? 8'h06 : 8'h15, run: m_run});
          i++;
`else
          rq.push_back('{b: 8'h06, run: m_run});
`endif
        end
      end else if (c == 8'h52) begin
        m_run = 1'b1;
        rq.push_back('{b: 8'h06, run: m_run});
      end else if (c == 8'h48) begin
        m_run = 1'b0;
        rq.push_back('{b: 8'h06, run: m_run});
      end else begin
        rq.push_back('{b: 8'h15, run: m_run});
      end
    end
  endtask

  task automatic send(input bq_t b);
    model_stream(b);
    foreach (b[k]) rxq.push_back(b[k]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((rxq.size() != 0 || wq.size() != 0 || rq.size() != 0 || pend || o_busy) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s: timeout rx=%0d wq=%0d rq=%0d busy=%0b", name, rxq.size(), wq.size(), rq.size(), o_busy);
    end
  endtask

  task automatic check_zero(input string name);
    logic [55:0] v;
    v = {o_rd, o_wr, o_wdata, o_tx_start, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_run, o_busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required 0", name, v);
    end
  endtask

  initial begin
    bq_t   b;
    wq32_t w;
    int    k;
    int    base;
    int    wr_seen;

    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    i_rst = 1'b1;

    // Reference load example.
    w = '{32'h00000013, 32'hDEADBEEF};
    send(mk_load(w, 1'b0));
    wait_idle("load2", 500);
`ifdef LOADER_CHECKSUM_EN
    send(mk_load(w, 1'b1));
    wait_idle("load2_badsum", 500);
`endif

    // Run / load-while-running / halt.
    b = '{8'h52}; send(b); wait_idle("run", 100);
    b = '{8'h4C}; send(b); wait_idle("load_running", 100);
    b = '{8'h48}; send(b); wait_idle("halt", 100);

    // Bad command and count bounds.
    b = '{8'h00}; send(b); wait_idle("bad_cmd", 100);
    b = '{8'h4C, 8'h01, 8'h04}; send(b); wait_idle("n1025", 100);
    w = {}; send(mk_load(w, 1'b0)); wait_idle("n0", 100);
    send(mk_load(rand_words(1024), 1'b0));
    wait_idle("n1024", 6000);

    // Back-pressure on the response.
    i_tx_full = 1'b1;
    b = '{8'h52}; send(b);
    wr_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_wr) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      errors++;
      $display("FAIL bp_hold: o_wr count=%0d required 0", wr_seen);
    end
    @(posedge clk); #1 i_tx_full = 1'b0;
    @(negedge clk);
    checks++;
    if (o_wr !== 1'b1 || o_wdata !== 8'h06) begin
      errors++;
      $display("FAIL bp_release: o_wr=%0b data=%h required 1/06", o_wr, o_wdata);
    end
    wait_idle("bp", 100);
    b = '{8'h48}; send(b); wait_idle("halt2", 100);

    // Same load gap-free and with random RX gaps.
    w = rand_words(6);
    send(mk_load(w, 1'b0)); wait_idle("gapfree", 500);
    gap_en = 1'b1;
    send(mk_load(w, 1'b0)); wait_idle("gapped", 2000);

    // Random command mix.
    for (int it = 0; it < 25; it++) begin
      gap_en = $urandom_range(0, 1) == 1;
      k = $urandom_range(0, 4);
      if (k == 0) begin
        b = '{8'h52}; send(b);
      end else if (k == 1) begin
        b = '{8'h48}; send(b);
      end else if (k == 2) begin
        b = '{8'($urandom_range(0, 8'h40))}; send(b);
      end else if (m_run) begin
        b = '{8'h4C}; send(b);
      end else begin
        send(mk_load(rand_words($urandom_range(0, 6)), $urandom_range(0, 3) == 0));
      end
      wait_idle("random", 2000);
    end

    // Reset in the middle of a two-word load.
    b = '{8'h48}; send(b); wait_idle("halt3", 100);
    gap_en = 1'b0;
    base = pop_cnt;
    send(mk_load(rand_words(2), 1'b0));
    k = 0;
    while (pop_cnt < base + 6 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    checks++;
    if (k >= 200) begin
      errors++;
      $display("FAIL mid_reset_wait: popped=%0d required 6", pop_cnt - base);
    end
    i_rst = 1'b0;
    #1 check_zero("async_reset");
    rxq.delete(); wq.delete(); rq.delete();
    pend = 1'b0; m_run = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b1;
    send(mk_load(rand_words(2), 1'b0));
    wait_idle("after_reset", 500);

    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain: writes=%0d resps=%0d outstanding", wq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
